// File: rtl/mips_pkg.sv
// Shared MIPS constants: instruction field positions, opcodes,
// NOP encoding and the IF/ID skid-stage state type.
package mips_pkg;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2b;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_e;
endpackage

// File: rtl/if_id_skid_stage_if.sv
// Valid/ready word bus between fetch and decode.
// master drives the word; slave returns ready.
interface if_id_skid_stage_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  logic          valid;
  logic          ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;

  modport master (
    output valid, instr, pc, pc_next,
    input  ready
  );
  modport slave (
    input  valid, instr, pc, pc_next,
    output ready
  );
endinterface

// File: rtl/if_id_slot.sv
// One IF/ID storage slot: {instr, pc, pc_next} with
// load enable and synchronous clear.
module if_id_slot #(
  parameter int AW = 32,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] d_instr,
  input  logic [AW-1:0] d_pc,
  input  logic [AW-1:0] d_pc_next,
  output logic [IW-1:0] q_instr,
  output logic [AW-1:0] q_pc,
  output logic [AW-1:0] q_pc_next
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_instr   <= '0;
      q_pc      <= '0;
      q_pc_next <= '0;
    end else if (en) begin
      q_instr   <= d_instr;
      q_pc      <= d_pc;
      q_pc_next <= d_pc_next;
    end
  end
endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage with 2-entry skid buffer, flush and
// MIPS field decode of the held instruction.
import mips_pkg::*;

module if_id_skid_stage #(
  parameter int          AW           = 32,
  parameter int          IW           = 32,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF,
  parameter bit          CLR_ON_FLUSH = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  if_id_skid_stage_if.slave   fetch,
  if_id_skid_stage_if.master  decode,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [15:0]         imm16,
  output logic [25:0]         target26
);
  skid_state_e state, state_nx;
  logic rdy_q, rdy_nx;
  logic accept, pop, out_valid;
  logic m_ld_in, m_ld_s, m_en, m_clr;
  logic s_ld;

  logic [IW-1:0] m_instr, s_instr, m_d_instr;
  logic [AW-1:0] m_pc, s_pc, m_d_pc;
  logic [AW-1:0] m_pcn, s_pcn, m_d_pcn;
  logic [IW-1:0] instr_o;

  assign out_valid = (state != EMPTY);
  assign accept    = fetch.valid & rdy_q;
  assign pop       = out_valid & decode.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nx;
      rdy_q <= rdy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    m_ld_in  = 1'b0;
    m_ld_s   = 1'b0;
    s_ld     = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            m_ld_in  = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_ld_in = 1'b1;
          end else if (accept) begin
            state_nx = TWO;
            s_ld     = 1'b1;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nx = ONE;
            m_ld_s   = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // ready mirrors "skid slot will be free next cycle"
  assign rdy_nx = (state_nx != TWO);

  assign m_en      = m_ld_in | m_ld_s;
  assign m_clr     = flush & CLR_ON_FLUSH;
  assign m_d_instr = m_ld_s ? s_instr : fetch.instr;
  assign m_d_pc    = m_ld_s ? s_pc    : fetch.pc;
  assign m_d_pcn   = m_ld_s ? s_pcn   : fetch.pc_next;

  if_id_slot #(.AW(AW), .IW(IW)) u_m (
    .clk       (clk),
    .rst       (rst),
    .clr       (m_clr),
    .en        (m_en),
    .d_instr   (m_d_instr),
    .d_pc      (m_d_pc),
    .d_pc_next (m_d_pcn),
    .q_instr   (m_instr),
    .q_pc      (m_pc),
    .q_pc_next (m_pcn)
  );

  if_id_slot #(.AW(AW), .IW(IW)) u_s (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .en        (s_ld),
    .d_instr   (fetch.instr),
    .d_pc      (fetch.pc),
    .d_pc_next (fetch.pc_next),
    .q_instr   (s_instr),
    .q_pc      (s_pc),
    .q_pc_next (s_pcn)
  );

  assign instr_o = out_valid ? m_instr : NOP_INSTR[IW-1:0];

  assign fetch.ready    = rdy_q;
  assign decode.valid   = out_valid;
  assign decode.instr   = instr_o;
  assign decode.pc      = m_pc;
  assign decode.pc_next = m_pcn;

  assign opcode   = instr_o[OP_HI:OP_LO];
  assign rs       = instr_o[RS_HI:RS_LO];
  assign rt       = instr_o[RT_HI:RT_LO];
  assign rd       = instr_o[RD_HI:RD_LO];
  assign imm16    = instr_o[IMM_HI:IMM_LO];
  assign target26 = instr_o[TGT_HI:TGT_LO];
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: accepted words are queued
// and compared in order as decode consumes them.
module tb_if_id_skid_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  if_id_skid_stage_if #(.AW(32), .IW(32)) fi ();
  if_id_skid_stage_if #(.AW(32), .IW(32)) fo ();
  if_id_skid_stage_if #(.AW(32), .IW(32)) fi0 ();
  if_id_skid_stage_if #(.AW(32), .IW(32)) fo0 ();

  logic [5:0]  opcode, opcode0;
  logic [4:0]  rs, rt, rd, rs0, rt0, rd0;
  logic [15:0] imm16, imm0;
  logic [25:0] tgt, tgt0;

  assign fi0.valid   = fi.valid;
  assign fi0.instr   = fi.instr;
  assign fi0.pc      = fi.pc;
  assign fi0.pc_next = fi.pc_next;
  assign fo0.ready   = fo.ready;

  if_id_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch(fi.slave), .decode(fo.master),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .target26(tgt)
  );

  if_id_skid_stage #(.CLR_ON_FLUSH(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch(fi0.slave), .decode(fo0.master),
    .opcode(opcode0), .rs(rs0), .rt(rt0), .rd(rd0),
    .imm16(imm0), .target26(tgt0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcn;
  } word_t;

  word_t sb[$];
  int    pop_cyc[$];
  int    cyc = 0;
  word_t w;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (fo.valid && fo.ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          w = sb.pop_front();
          chk("instr", fo.instr, w.instr);
          chk("pc", fo.pc, w.pc);
          chk("pc_next", fo.pc_next, w.pcn);
          chk("opcode", opcode, w.instr[31:26]);
          chk("rs", rs, w.instr[25:21]);
          chk("rt", rt, w.instr[20:16]);
          chk("rd", rd, w.instr[15:11]);
          chk("imm16", imm16, w.instr[15:0]);
          chk("target26", tgt, w.instr[25:0]);
          pop_cyc.push_back(cyc);
        end
      end
      if (fi.valid && fi.ready)
        sb.push_back('{fi.instr, fi.pc, fi.pc_next});
    end
    if (!fo.valid) chk("nop_idle", fo.instr, NOP_INSTR_DEF);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] i, logic [31:0] p);
    fi.valid   = 1'b1;
    fi.instr   = i;
    fi.pc      = p;
    fi.pc_next = p + 32'd4;
  endtask

  task automatic send(logic [31:0] i, logic [31:0] p);
    int n;
    n = 0;
    drive(i, p);
    while (!fi.ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("send_timeout", n, 0);
    step();
    fi.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int base;
  int c0;

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    fo.ready = 1'b0;
    drive(32'h1234_5678, 32'h0000_0100);
    step();
    step();
    chk("rst_valid", fo.valid, 0);
    chk("rst_instr", fo.instr, 0);
    chk("rst_ready", fi.ready, 1);
    chk("rst_pc", fo.pc, 0);
    chk("rst_pcn", fo.pc_next, 0);
    rst      = 1'b0;
    fi.valid = 1'b0;
    step();

    // single lw, latency one cycle
    fo.ready = 1'b1;
    send(32'h8C22_0004, 32'h0040_0000);
    chk("lw_valid", fo.valid, 1);
    chk("lw_opcode", opcode, 6'h23);
    chk("lw_rs", rs, 1);
    chk("lw_rt", rt, 2);
    chk("lw_imm", imm16, 16'h0004);
    chk("lw_pcn", fo.pc_next, 32'h0040_0004);
    step();
    chk("lw_drained", fo.valid, 0);

    // back-pressure fills the skid slot
    fo.ready = 1'b0;
    send(32'h014B_4820, 32'h0000_1000);
    send(32'h8C43_0008, 32'h0000_1004);
    drive(32'hAC64_0010, 32'h0000_1008);
    chk("bp_ready", fi.ready, 0);
    chk("bp_head", fo.instr, 32'h014B_4820);
    chk("bp_pc", fo.pc, 32'h0000_1000);
    step();
    chk("bp_hold", fo.instr, 32'h014B_4820);
    chk("bp_ready2", fi.ready, 0);
    fo.ready = 1'b1;
    base = pop_cyc.size();
    send(32'hAC64_0010, 32'h0000_1008);
    step();
    step();
    chk("abc_count", pop_cyc.size() - base, 3);
    if (pop_cyc.size() - base >= 3)
      chk("abc_rate", pop_cyc[base+2] - pop_cyc[base], 2);

    // flush while full drops everything
    fo.ready = 1'b0;
    send(32'h8C43_0008, 32'h0000_2000);
    send(32'h0043_2020, 32'h0000_2004);
    chk("two_ready", fi.ready, 0);
    drive(32'hAC64_0010, 32'h0000_2008);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    fi.valid = 1'b0;
    chk("fl_valid", fo.valid, 0);
    chk("fl_ready", fi.ready, 1);
    chk("fl_instr", fo.instr, 0);
    chk("fl_pc", fo.pc, 0);
    chk("fl_pcn", fo.pc_next, 0);
    chk("fl_hold_pc", fo0.pc, 32'h0000_2000);
    chk("fl_hold_instr", fo0.instr, 0);
    fo.ready = 1'b1;
    step();
    step();
    step();
    chk("fl_gone", fo.valid, 0);

    // streaming, one word per cycle
    base = pop_cyc.size();
    c0   = cyc;
    for (int i = 0; i < 100; i++)
      send(32'h2000_0000 | i, 32'h0000_3000 + 32'(4 * i));
    chk("str_cycles", cyc - c0, 100);
    step();
    step();
    chk("str_count", pop_cyc.size() - base, 100);
    if (pop_cyc.size() - base >= 100)
      chk("str_rate", pop_cyc[base+99] - pop_cyc[base], 99);
    chk("sb_drained", sb.size(), 0);

    // reset beats flush while holding a word
    fo.ready = 1'b0;
    send(32'h0800_0010, 32'h0000_4000);
    chk("one_valid", fo.valid, 1);
    rst   = 1'b1;
    flush = 1'b1;
    drive(32'h1111_2222, 32'h0000_4004);
    step();
    rst      = 1'b0;
    flush    = 1'b0;
    fi.valid = 1'b0;
    chk("rr_valid", fo.valid, 0);
    chk("rr_instr", fo.instr, 0);
    chk("rr_ready", fi.ready, 1);
    chk("rr_pc", fo.pc, 0);
    chk("rr_pcn", fo.pc_next, 0);
    chk("rr_pc0", fo0.pc, 0);
    step();
    chk("rr_stay", fo.valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
